// File: rtl/ul_mul_sync_pkg.sv
// Shared uplink sequential-arithmetic definitions: default widths that pair the
// divider with its reconstruction multiplier, the handshake state type and a
// helper for sizing iteration counters.
package ul_mul_sync_pkg;

  // Quotient-side and divisor/remainder-side widths used by the uplink divider
  // and by this multiplier, so both blocks agree by construction.
  localparam int unsigned UL_QUO_W = 10;
  localparam int unsigned UL_DIV_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } ul_seq_state_e;

  // Bits needed for a counter that must hold values 0..n.
  function automatic int unsigned ul_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ul_mul_sync_if.sv
// start/busy/done handshake plus operand/result bus of the uplink multiplier.
interface ul_mul_sync_if
  import ul_mul_sync_pkg::*;
#(
  parameter int unsigned A_WIDTH = UL_QUO_W,
  parameter int unsigned B_WIDTH = UL_DIV_W
);
  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

  logic               start;
  logic               busy;
  logic               done;
  logic [A_WIDTH-1:0] multiplicand;
  logic [B_WIDTH-1:0] multiplier;
  logic [B_WIDTH-1:0] addend;
  logic [P_WIDTH-1:0] product;

  modport master (
    output start, multiplicand, multiplier, addend,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier, addend,
    output busy, done, product
  );

endinterface

// File: rtl/ul_mul_sync.sv
// Sequential shift-add multiply-accumulate: product = multiplicand*multiplier+addend,
// one multiplier bit per clock, fixed B_WIDTH-cycle latency.
module ul_mul_sync
  import ul_mul_sync_pkg::*;
#(
  parameter int unsigned A_WIDTH = UL_QUO_W,
  parameter int unsigned B_WIDTH = UL_DIV_W
)(
  input  logic clk,
  input  logic rst_n,
  ul_mul_sync_if.slave bus
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int unsigned CNT_W   = ul_cnt_width(B_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_WIDTH - 1);

  ul_seq_state_e      state;
  logic [CNT_W-1:0]   cnt;
  logic [P_WIDTH-1:0] acc;
  logic [P_WIDTH-1:0] mcand;
  logic [B_WIDTH-1:0] mplr;
  logic [P_WIDTH-1:0] product_q;
  logic               done_q;
  logic [P_WIDTH-1:0] acc_step;

  // Accumulator after this cycle's conditional add; also the final result.
  always_comb begin
    acc_step = acc;
    if (mplr[0]) begin
      acc_step = acc + mcand;
    end
  end

  // Handshake FSM and shift-add datapath; product only moves on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state <= ST_BUSY;
            cnt   <= '0;
            acc   <= P_WIDTH'(bus.addend);
            mcand <= P_WIDTH'(bus.multiplicand);
            mplr  <= bus.multiplier;
          end
        end
        ST_BUSY: begin
          acc   <= acc_step;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state     <= ST_IDLE;
            done_q    <= 1'b1;
            product_q <= acc_step;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == ST_BUSY);
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: doc/ul_mul_sync.md
Name: ul_mul_sync

Overview:
Sequential shift-add multiply-accumulate that computes product = multiplicand * multiplier + addend, one multiplier bit per clock. It is the reconstruction direction of the uplink sequential divider: it rebuilds dividend = quotient * divisor + remainder. It is also the general small multiplier for uplink index and address computations. It uses the same start/busy/done handshake as the other uplink sequential arithmetic blocks.

Parameters:
A_WIDTH, 10, multiplicand width (quotient-side width)
B_WIDTH, 8, multiplier and addend width (divisor/remainder-side width); must be >= 1
P_WIDTH, A_WIDTH+B_WIDTH, product width (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; accepted only when busy=0
busy  output  1  operation in progress
done  output  1  one-cycle pulse when product updates
multiplicand  input  A_WIDTH  operand a; sampled on accepted start
multiplier  input  B_WIDTH  operand b; sampled on accepted start
addend  input  B_WIDTH  operand c, zero-extended; sampled on accepted start
product  output  P_WIDTH  registered result a*b+c; held until next completion

Behaviour:
- Reset values: busy=0, done=0, product=0. Internal accumulator, shifted multiplicand, shifted multiplier and counter all reset to 0.
- Accept: at a rising edge with start=1 and busy=0:
  - busy<=1, cnt<=0.
  - acc<=zero-extended addend.
  - mcand<=zero-extended multiplicand (P_WIDTH bits).
  - mplr<=multiplier.
- Start while busy: start with busy=1 is ignored. It does not restart the operation and does not disturb the operands in flight.
- Iterate: each edge with busy=1:
  - if mplr[0], acc<=acc+mcand (P_WIDTH arithmetic, no truncation possible); otherwise acc is unchanged.
  - mcand<=mcand<<1; mplr<=mplr>>1; cnt<=cnt+1.
- Finish: on the busy edge where cnt==B_WIDTH-1:
  - busy<=0, done<=1.
  - product<=the acc value including this last step's conditional add.
- Latency: start accepted at edge E. busy is high for exactly B_WIDTH cycles (edges E+1..E+B_WIDTH perform the steps). done is high, and product is valid, in the cycle after edge E+B_WIDTH.
- done: high for exactly one cycle per accepted start; otherwise 0.
- product: changes only on the done-setting edge and on reset. It is stable during busy, so the previous result stays readable.
- Back-to-back: busy=0 during the done cycle, so a start in that cycle is accepted. The next done then arrives B_WIDTH+1 cycles after the previous done.
- Range: the maximum result (2^A_WIDTH-1)(2^B_WIDTH-1)+(2^B_WIDTH-1) = (2^B_WIDTH-1)*2^A_WIDTH fits in P_WIDTH. No overflow flag.
- Zero operands: multiplier=0 or multiplicand=0 still takes the full B_WIDTH cycles (no early exit), giving product=addend. Timing is data-independent.
- Counter width: $clog2(B_WIDTH+1) bits. For B_WIDTH=1, the single busy cycle is the finishing cycle.
- Reset mid-operation: everything returns to reset values immediately, with no done pulse. The first start after release is accepted normally.
- Operand inputs may change freely after the accepting edge.

Decomposition:
- Shared uplink arithmetic package holds:
  - the default widths (UL_QUO_W=10, UL_DIV_W=8), so the divider and this block pair up by construction;
  - a function for the counter width.
- No sub-module. The iteration datapath (conditional adder plus two shifters) stays inline. A standalone adder gains nothing.

Test Plan:
- Reset then idle (A_WIDTH=10, B_WIDTH=8) -> busy=0, done=0, product=0; no done pulse with start held low for 20 cycles.
- a=37, b=11, c=5, one-cycle start -> busy high exactly 8 cycles, then done pulse for 1 cycle, product=412; product holds 412 thereafter.
- a=1023, b=255, c=255 -> product=261120 (max case, no overflow). Then a=0, b=200, c=7 -> product=7 after the same 8-cycle latency.
- Start re-asserted at the 3rd busy cycle of a=37, b=11, c=5 with different operands a=1, b=1, c=0 -> ignored; result 412 at the normal time.
- Start asserted in the done cycle with a=100, b=3, c=2 -> accepted; product stays at the prior value until the next done 9 cycles later, then product=302.
- rst_n pulsed low at the 4th busy cycle -> busy=0, done=0, product=0 asynchronously, no done pulse. Randomized a/b/c checked against a*b+c for 1000 operations, and against divider round-trip (quotient, divisor, remainder) -> dividend.
